fetch_mem_resp: RTL and testbench
=================================

# fetch_mem_resp

Responder side of the instruction-fetch request interface: accepts one instruction request at a time from the fetch stage and returns one 32-bit instruction with a single-cycle valid pulse. Each instruction is assembled from two beats of a 16-bit instruction memory bus. An optional direct-mapped instruction cache sits between the two sides. The block sits between the fetch stage and the instruction memory/bus arbiter.

## Interface
Parameters:
- ICACHE_LINES, 16, number of cache lines (power of 2, ≥2); one instruction per line; ignored without ICACHE_EN

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset: synchronous, active-high
- i_req_addr  in  `RW  instruction address (word = one instruction)
- i_req_active  in  1  fetch requests an instruction (level)
- o_req_data  out  `I_SIZE  returned instruction
- o_req_data_valid  out  1  one-cycle pulse: o_req_data valid
- o_mem_addr  out  `RW+1  16-bit memory word address
- o_mem_req  out  1  bus request, held until ack
- i_mem_ack  in  1  beat done; i_mem_data valid this cycle
- i_mem_data  in  16  beat data
- i_cache_inv  in  1  invalidate all cache lines (ignored without ICACHE_EN)

## Operation
- States: IDLE, LOOKUP (ICACHE_EN only), LO, HI, RESP.
- IDLE: if i_req_active, latch i_req_addr into addr_q and go to LOOKUP (or LO without the cache). Otherwise stay in IDLE.
- All later use of the address comes from addr_q. Changes on i_req_addr mid-transaction are ignored.
- LOOKUP: index = addr_q[log2(ICACHE_LINES)-1:0], tag = remaining upper bits.
  - Hit (valid & tag match): load o_req_data from the line, go to RESP.
  - Miss: go to LO.
- LO: o_mem_req=1, o_mem_addr={addr_q,1'b0}. On i_mem_ack, capture i_mem_data into o_req_data[15:0] and go to HI.
- HI: o_mem_req=1, o_mem_addr={addr_q,1'b1}. On i_mem_ack, capture i_mem_data into o_req_data[31:16] and go to RESP. With the cache, write the assembled line (valid, tag, data) on this edge.
- RESP: o_req_data_valid=1 for exactly this cycle, then go to IDLE.
  - i_req_active is not sampled in RESP. Fetch updates its address on the valid edge, so the next request is latched no earlier than the IDLE cycle that follows.
- A started transaction always completes and pulses valid, even if i_req_active drops. The requester discards stale responses itself (flush); this block has no abort.
- o_req_data holds its value between pulses.
- i_cache_inv: clears all valid bits on the next edge.
  - If asserted while a fill is in flight (LOOKUP-miss/LO/HI), that fill's line write is suppressed.
  - If inv and the line write land on the same edge, inv wins: the line stays invalid.
  - The response is still returned.

## Timing
- Reset: state IDLE, o_req_data=0, o_req_data_valid=0, o_mem_req=0, o_mem_addr=0, all cache valid bits cleared.
- Reset mid-transaction aborts it: o_mem_req drops at the reset edge and any later ack is ignored while in IDLE.
- i_mem_ack is honoured only while o_mem_req=1. The earliest ack is the first cycle o_mem_req is high. o_mem_addr is stable while o_mem_req=1 and no ack has occurred.
- Latency, request latched at edge of cycle N, zero-wait memory (ack in first req cycle):
  - Without ICACHE_EN: LO at N+1, HI at N+2, valid at N+3.
  - ICACHE_EN, hit: valid at N+2.
  - ICACHE_EN, miss: LOOKUP at N+1, LO at N+2, HI at N+3, valid at N+4.
- Each memory wait cycle adds one cycle.
- Back-to-back throughput: one instruction per 4 cycles (no cache) or per 3 cycles (cache hits).

## Configuration
- ICACHE_EN defined: the LOOKUP state, tag/valid/data arrays and i_cache_inv handling are compiled in.
- ICACHE_EN undefined: IDLE goes directly to LO, every request goes to memory, and i_cache_inv is unconnected internally. Port list is identical in both builds.

## Structure
- `RW and `I_SIZE come from config.v.
- State encodings are local constants.
- Cache index/tag widths are derived from ICACHE_LINES inside the block.
- Sub-module icache_mem holds the tag/valid/data arrays:
  - One combinational read port (index → hit, data).
  - One synchronous write port.
  - Global clear for i_cache_inv and reset.
  - Instantiated only under ICACHE_EN.

## Test plan
- No cache, zero-wait memory: req addr 0x0012, beats 0x100e then 0x0040 → o_mem_addr 0x00024 then 0x00025; o_req_data=0x0040100e pulsed at N+3.
- Memory with 2 wait cycles per beat: valid at N+7; o_mem_addr held stable throughout; exactly one pulse.
- i_req_addr changed from 0x0012 to 0x0050 at N+2 → data still from 0x0012; next request latched only in the IDLE cycle after RESP.
- ICACHE_EN: fetch 0x0003 (miss, valid N+4), then 0x0003 again → hit, valid at N+2, no o_mem_req. Then 0x0013 with 16 lines (same index) → miss and refill.
- ICACHE_EN: i_cache_inv asserted during HI of a fill of 0x0007 → response returned; a re-request of 0x0007 misses.
- i_rst asserted during LO → o_mem_req=0 next cycle; a late ack produces no valid pulse; all outputs at reset values.

Source files
------------

// File: rtl/fetch_mem_resp_pkg.sv
// fetch_mem_resp_pkg
// Shared widths and helpers for the instruction-fetch responder.
// RW (instruction address width) and I_SIZE (instruction width) normally
// come from the project config.v. The fallbacks below are only used when
// that file has not been read ahead of this package.
`ifndef RW
`define RW 16
`endif
`ifndef I_SIZE
`define I_SIZE 32
`endif

package fetch_mem_resp_pkg;
   localparam int RW     = `RW;
   localparam int I_SIZE = `I_SIZE;
   localparam int BEAT_W = 16;   // instruction memory bus width

   // 16-bit memory word address of one half of an instruction
   function automatic logic [RW:0] beat_addr(input logic [RW-1:0] addr, input logic hi);
      return {addr, hi};
   endfunction
endpackage

// File: rtl/fetch_mem_resp_icache.sv
// icache_mem
// Tag/valid/data storage for the direct-mapped instruction cache, one
// instruction per line.
// Ports:
//   i_clk            clock
//   i_clr            clears every valid bit on the next edge (reset or invalidate)
//   rd_idx, rd_tag   combinational lookup -> rd_hit, rd_data
//   wr_en, wr_idx,
//   wr_tag, wr_data  synchronous line write (sets the line valid)
// A clear takes priority over a write landing on the same edge.
module icache_mem #(
   parameter int LINES  = 16,
   parameter int IDX_W  = $clog2(LINES),
   parameter int TAG_W  = 12,
   parameter int DATA_W = 32
) (
   input  logic              i_clk,
   input  logic              i_clr,
   input  logic [IDX_W-1:0]  rd_idx,
   input  logic [TAG_W-1:0]  rd_tag,
   output logic              rd_hit,
   output logic [DATA_W-1:0] rd_data,
   input  logic              wr_en,
   input  logic [IDX_W-1:0]  wr_idx,
   input  logic [TAG_W-1:0]  wr_tag,
   input  logic [DATA_W-1:0] wr_data
);
   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_arr  [LINES];
   logic [DATA_W-1:0] data_arr [LINES];

   assign rd_hit  = valid[rd_idx] && (tag_arr[rd_idx] == rd_tag);
   assign rd_data = data_arr[rd_idx];

   always_ff @(posedge i_clk) begin
      if (i_clr)
         valid <= '0;
      else if (wr_en)
         valid[wr_idx] <= 1'b1;
   end

   // Payload needs no reset: a line is never read as a hit until valid is set.
   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         tag_arr[wr_idx]  <= wr_tag;
         data_arr[wr_idx] <= wr_data;
      end
   end
endmodule

// File: rtl/fetch_mem_resp.sv
// fetch_mem_resp
// Responder for instruction-fetch requests. Latches one request, reads the
// instruction as two 16-bit beats (low half first) from instruction memory
// and returns it with a one-cycle valid pulse. Optional direct-mapped cache.
// Build option: define ICACHE_EN to compile in the cache (LOOKUP state,
// icache_mem, i_cache_inv handling). Port list is the same either way.
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_req_addr/i_req_active instruction request (level)
//   o_req_data/_valid       instruction and its one-cycle valid pulse
//   o_mem_addr/o_mem_req    memory beat request, held until i_mem_ack
//   i_mem_ack/i_mem_data    beat completion and data
//   i_cache_inv             invalidate all cache lines
module fetch_mem_resp
   import fetch_mem_resp_pkg::*;
#(
   parameter int ICACHE_LINES = 16
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [RW-1:0]     i_req_addr,
   input  logic              i_req_active,
   output logic [I_SIZE-1:0] o_req_data,
   output logic              o_req_data_valid,
   output logic [RW:0]       o_mem_addr,
   output logic              o_mem_req,
   input  logic              i_mem_ack,
   input  logic [BEAT_W-1:0] i_mem_data,
   input  logic              i_cache_inv
);
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_LO     = 3'd2,
      S_HI     = 3'd3,
      S_RESP   = 3'd4
   } state_t;

   state_t        state;
   logic [RW-1:0] addr_q;
   logic          ack;

   // Acks are only meaningful while a beat is being requested.
   assign ack = i_mem_ack && o_mem_req;

`ifdef ICACHE_EN
   localparam int IDX_W = $clog2(ICACHE_LINES);
   localparam int TAG_W = RW - IDX_W;

   logic              hit;
   logic [I_SIZE-1:0] hit_data;
   logic              fill_kill;   // invalidate seen during this fill
   logic              line_we;

   // Inv on the write edge itself also blocks the write.
   assign line_we = (state == S_HI) && ack && !fill_kill && !i_cache_inv;

   icache_mem #(
      .LINES  (ICACHE_LINES),
      .IDX_W  (IDX_W),
      .TAG_W  (TAG_W),
      .DATA_W (I_SIZE)
   ) u_icache_mem (
      .i_clk   (i_clk),
      .i_clr   (i_rst || i_cache_inv),
      .rd_idx  (addr_q[IDX_W-1:0]),
      .rd_tag  (addr_q[RW-1:IDX_W]),
      .rd_hit  (hit),
      .rd_data (hit_data),
      .wr_en   (line_we),
      .wr_idx  (addr_q[IDX_W-1:0]),
      .wr_tag  (addr_q[RW-1:IDX_W]),
      .wr_data ({i_mem_data, o_req_data[BEAT_W-1:0]})
   );
`else
   logic unused_nocache;
   assign unused_nocache = i_cache_inv ^ ICACHE_LINES[0];
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state            <= S_IDLE;
         addr_q           <= '0;
         o_req_data       <= '0;
         o_req_data_valid <= 1'b0;
         o_mem_req        <= 1'b0;
         o_mem_addr       <= '0;
`ifdef ICACHE_EN
         fill_kill        <= 1'b0;
`endif
      end else begin
         o_req_data_valid <= 1'b0;
`ifdef ICACHE_EN
         if (i_cache_inv && (state == S_LOOKUP || state == S_LO || state == S_HI))
            fill_kill <= 1'b1;
`endif
         case (state)
            S_IDLE: begin
               if (i_req_active) begin
                  addr_q <= i_req_addr;
`ifdef ICACHE_EN
                  fill_kill <= 1'b0;
                  state     <= S_LOOKUP;
`else
                  state      <= S_LO;
                  o_mem_req  <= 1'b1;
                  o_mem_addr <= beat_addr(i_req_addr, 1'b0);
`endif
               end
            end
`ifdef ICACHE_EN
            S_LOOKUP: begin
               if (hit) begin
                  o_req_data       <= hit_data;
                  o_req_data_valid <= 1'b1;
                  state            <= S_RESP;
               end else begin
                  o_mem_req  <= 1'b1;
                  o_mem_addr <= beat_addr(addr_q, 1'b0);
                  state      <= S_LO;
               end
            end
`endif
            S_LO: begin
               if (ack) begin
                  o_req_data[BEAT_W-1:0] <= i_mem_data;
                  o_mem_addr             <= beat_addr(addr_q, 1'b1);
                  state                  <= S_HI;
               end
            end
            S_HI: begin
               if (ack) begin
                  o_req_data[2*BEAT_W-1:BEAT_W] <= i_mem_data;
                  o_mem_req                     <= 1'b0;
                  o_req_data_valid              <= 1'b1;
                  state                         <= S_RESP;
               end
            end
            // Request is not sampled here; the requester moves its address on
            // the valid edge, so the next latch happens in the following IDLE.
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_mem_resp.sv
module tb_fetch_mem_resp;
   import fetch_mem_resp_pkg::*;

`ifdef ICACHE_EN
   localparam int LAT_MISS = 4, LAT_HIT = 2, HIT_REQS = 0;
`else
   localparam int LAT_MISS = 3, LAT_HIT = 3, HIT_REQS = 2;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [RW-1:0]     req_addr = '0;
   logic              req_active = 1'b0;
   logic [I_SIZE-1:0] req_data;
   logic              req_valid;
   logic [RW:0]       mem_addr;
   logic              mem_req;
   logic              mem_ack;
   logic [15:0]       mem_data;
   logic              cache_inv;

   always #5 clk = ~clk;

   fetch_mem_resp #(.ICACHE_LINES(16)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_req_addr       (req_addr),
      .i_req_active     (req_active),
      .o_req_data       (req_data),
      .o_req_data_valid (req_valid),
      .o_mem_addr       (mem_addr),
      .o_mem_req        (mem_req),
      .i_mem_ack        (mem_ack),
      .i_mem_data       (mem_data),
      .i_cache_inv      (cache_inv)
   );

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] exp_q[$];
   int          waits = 0;
   bit          force_ack = 0, inv_arm = 0, inv_force = 0;
   int          req_cycles = 0;
   logic [15:0] mem [0:255];

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, want);
      end
   endtask

   // Memory model: waits cycles before each ack; checks address stability.
   initial begin
      int wcnt;
      logic [RW:0] held;
      wcnt = 0; held = '0;
      mem_ack = 0; mem_data = 0; cache_inv = 0;
      forever begin
         @(negedge clk);
         mem_ack = 0;
         cache_inv = inv_force || (inv_arm && mem_req && mem_addr[0]);
         if (mem_req) begin
            req_cycles++;
            if (wcnt == 0) held = mem_addr;
            else chk("addr_stable", 64'(mem_addr), 64'(held));
            if (wcnt >= waits) begin
               mem_ack = 1; mem_data = mem[mem_addr[7:0]]; wcnt = 0;
            end else wcnt++;
         end else begin
            wcnt = 0;
            if (force_ack) begin mem_ack = 1; mem_data = 16'hffff; end
         end
      end
   end

   // Scoreboard monitor
   initial forever begin
      @(negedge clk);
      if (req_valid === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_valid", 64'(req_data), 64'hdead_0000_0000);
         else chk("resp_data", 64'(req_data), 64'(exp_q.pop_front()));
      end
   end

   // Issue one request (held for one edge) and measure edges-to-valid.
   task automatic fetch(input logic [RW-1:0] a, input logic [31:0] e, input int lat, input string nm);
      int got;
      got = -1;
      @(negedge clk); req_addr = a; req_active = 1; exp_q.push_back(e);
      @(posedge clk);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 1) req_active = 0;
         if (req_valid) begin got = k; break; end
      end
      chk({nm, "_latency"}, 64'(got), 64'(lat));
   endtask

   task automatic inv_pulse();
      @(negedge clk); inv_force = 1;
      @(negedge clk); inv_force = 0;
   endtask

   initial begin
      int r0, first, second;
      for (int i = 0; i < 256; i++) mem[i] = 16'h0;
      mem[8'h24] = 16'h100e; mem[8'h25] = 16'h0040;
      mem[8'ha0] = 16'hbeef; mem[8'ha1] = 16'hdead;
      mem[8'h06] = 16'h5678; mem[8'h07] = 16'h1234;
      mem[8'h26] = 16'h0bad; mem[8'h27] = 16'hf00d;
      mem[8'h0e] = 16'h2222; mem[8'h0f] = 16'h1111;

      repeat (3) @(negedge clk);
      chk("rst_valid", 64'(req_valid), 0);
      chk("rst_mem_req", 64'(mem_req), 0);
      chk("rst_mem_addr", 64'(mem_addr), 0);
      chk("rst_data", 64'(req_data), 0);
      rst = 0;

      fetch(16'h0012, 32'h0040100e, LAT_MISS, "zero_wait");

      inv_pulse();
      waits = 2;
      fetch(16'h0012, 32'h0040100e, LAT_MISS + 4, "wait2");
      waits = 0;

      // Address changes mid-transaction; request held, so second latch
      // happens in the IDLE after RESP.
      inv_pulse();
      first = -1; second = -1;
      @(negedge clk); req_addr = 16'h0012; req_active = 1;
      exp_q.push_back(32'h0040100e); exp_q.push_back(32'hdeadbeef);
      @(posedge clk);
      for (int k = 1; k <= 60; k++) begin
         @(negedge clk);
         if (k == 2) req_addr = 16'h0050;
         if (req_valid) begin
            if (first < 0) first = k;
            else begin second = k; break; end
         end
      end
      req_active = 0;
      chk("addr_change_first", 64'(first), 64'(LAT_MISS));
      chk("addr_change_gap", 64'(second - first), 64'(LAT_MISS + 1));

      repeat (3) @(negedge clk);
      chk("data_hold", 64'(req_data), 64'h00000000deadbeef);

      fetch(16'h0003, 32'h12345678, LAT_MISS, "miss_0003");
      r0 = req_cycles;
      fetch(16'h0003, 32'h12345678, LAT_HIT, "hit_0003");
      chk("hit_mem_reqs", 64'(req_cycles - r0), 64'(HIT_REQS));
      fetch(16'h0013, 32'hf00d0bad, LAT_MISS, "conflict_0013");
      fetch(16'h0003, 32'h12345678, LAT_MISS, "evicted_0003");

      inv_arm = 1;
      fetch(16'h0007, 32'h11112222, LAT_MISS, "inv_fill_0007");
      inv_arm = 0;
      fetch(16'h0007, 32'h11112222, LAT_MISS, "after_inv_0007");

      // Reset during LO aborts the transaction.
      waits = 5;
      @(negedge clk); req_addr = 16'h0012; req_active = 1;
      @(posedge clk);
      @(negedge clk); req_active = 0;
      @(negedge clk);
      chk("pre_rst_mem_req", 64'(mem_req), 1);
      rst = 1;
      @(negedge clk); rst = 0;
      chk("abort_mem_req", 64'(mem_req), 0);
      chk("abort_valid", 64'(req_valid), 0);
      chk("abort_data", 64'(req_data), 0);
      chk("abort_mem_addr", 64'(mem_addr), 0);
      force_ack = 1;
      repeat (3) @(negedge clk);
      force_ack = 0;
      repeat (4) @(negedge clk);
      chk("late_ack_mem_req", 64'(mem_req), 0);
      waits = 0;

      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
